// File: rtl/vga_stream_pkg.sv
// ---------------------------------------------------------------------------
// vga_stream_pkg
// Shared definitions for the VGA stream source:
//   - bit positions of every field in the 26-bit RGB stream word
//   - default 640x480@60 timing constants (800 x 525 totals)
//   - the stream word typedef and its reset value
// No ports (package).
// ---------------------------------------------------------------------------
package vga_stream_pkg;

    // Stream word field positions
    localparam int ACTIVE_BIT = 0;
    localparam int VS_BIT     = 1;
    localparam int HS_BIT     = 2;
    localparam int YC_LSB     = 3;
    localparam int YC_MSB     = 12;
    localparam int XC_LSB     = 13;
    localparam int XC_MSB     = 22;
    localparam int R_BIT      = 23;
    localparam int G_BIT      = 24;
    localparam int B_BIT      = 25;
    localparam int RGB_LSB    = 23;
    localparam int RGB_MSB    = 25;
    // Raw VGA control triplet {HS, VS, Active}
    localparam int VGA_LSB    = 0;
    localparam int VGA_MSB    = 2;

    localparam int COORD_W    = 10;

    // Default 640x480 timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef logic [25:0] rgb_stream_t;

    // Word driven while in reset: syncs idle high, everything else zero
    localparam rgb_stream_t IDLE_WORD = 26'h000_0006;

endpackage

// File: rtl/vga_stream_source_if.sv
// ---------------------------------------------------------------------------
// vga_stream_source_if
// Bundles the colour input and the stream outputs of vga_stream_source.
//   bg_color    : {B,G,R} background colour into the source
//   rgb_str     : 26-bit stream word out of the source
//   frame_start : pulse on the word with XC=0, YC=0
//   line_start  : pulse on every word with XC=0
// Modports: master = the stream source, slave = the stream consumer.
// ---------------------------------------------------------------------------
interface vga_stream_source_if;
    import vga_stream_pkg::*;

    logic [2:0]  bg_color;
    rgb_stream_t rgb_str;
    logic        frame_start;
    logic        line_start;

    modport master (
        input  bg_color,
        output rgb_str,
        output frame_start,
        output line_start
    );

    modport slave (
        output bg_color,
        input  rgb_str,
        input  frame_start,
        input  line_start
    );

endinterface

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Wrap counter: counts 0..MAX while en_i is high, then wraps to 0.
// Ports:
//   clk     : clock
//   srst    : synchronous active-high reset (count -> 0)
//   en_i    : count enable
//   count_o : current count
// ---------------------------------------------------------------------------
module mod_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 799
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == WIDTH'(MAX)) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vga_stream_source.sv
// ---------------------------------------------------------------------------
// vga_stream_source
// Generates a VGA timing stream: pixel/line counters, sync and active flags,
// coordinates and colour, all registered one cycle after the counter state.
// Ports:
//   px_clk      : pixel clock (only clock)
//   reset       : synchronous active-high reset
//   bg_color    : {B,G,R} colour for active pixels when no test pattern
//   RGBStr_o    : 26-bit stream {B,G,R,XC[9:0],YC[9:0],HS,VS,Active}
//   frame_start : one-cycle pulse on the word with XC=0, YC=0
//   line_start  : one-cycle pulse on every word with XC=0
// Build option:
//   TEST_PATTERN_EN : when defined, active colour is an 8-bar colour index
//                     ({B,G,R}=bar) and bg_color is ignored.
// ---------------------------------------------------------------------------
module vga_stream_source
    import vga_stream_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic [2:0]  bg_color,
    output rgb_stream_t RGBStr_o,
    output logic        frame_start,
    output logic        line_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [COORD_W-1:0] hc;
    logic [COORD_W-1:0] vc;
    logic               hc_last;

    assign hc_last = (hc == COORD_W'(H_TOTAL - 1));

    mod_counter #(.WIDTH(COORD_W), .MAX(H_TOTAL - 1)) u_hc (
        .clk     (px_clk),
        .srst    (reset),
        .en_i    (1'b1),
        .count_o (hc)
    );

    // Vertical counter only moves on the horizontal wrap cycle
    mod_counter #(.WIDTH(COORD_W), .MAX(V_TOTAL - 1)) u_vc (
        .clk     (px_clk),
        .srst    (reset),
        .en_i    (hc_last),
        .count_o (vc)
    );

    logic [2:0] active_rgb;

`ifdef TEST_PATTERN_EN
    // Bar index tracks hc incrementally: a pixel-within-bar counter steps the
    // bar every BAR_W pixels, and both restart when the line wraps.
    localparam int BAR_W = H_ACTIVE / 8;

    logic [COORD_W-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]         bar_q, bar_d;

    always_comb begin
        bar_pix_d = bar_pix_q;
        bar_d     = bar_q;
        if (hc_last) begin
            bar_pix_d = '0;
            bar_d     = '0;
        end else if (bar_pix_q == COORD_W'(BAR_W - 1)) begin
            bar_pix_d = '0;
            bar_d     = bar_q + 3'd1;
        end else begin
            bar_pix_d = bar_pix_q + COORD_W'(1);
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            bar_pix_q <= '0;
            bar_q     <= '0;
        end else begin
            bar_pix_q <= bar_pix_d;
            bar_q     <= bar_d;
        end
    end

    assign active_rgb = bar_q;
`else
    assign active_rgb = bg_color;
`endif

    logic        active_d;
    logic        hs_d;
    logic        vs_d;
    rgb_stream_t word_d;
    rgb_stream_t stream_q;
    logic        frame_start_q;
    logic        line_start_q;

    always_comb begin
        active_d = (hc < COORD_W'(H_ACTIVE)) && (vc < COORD_W'(V_ACTIVE));
        hs_d     = !((hc >= COORD_W'(HS_START)) && (hc < COORD_W'(HS_END)));
        vs_d     = !((vc >= COORD_W'(VS_START)) && (vc < COORD_W'(VS_END)));

        word_d                  = '0;
        word_d[ACTIVE_BIT]      = active_d;
        word_d[VS_BIT]          = vs_d;
        word_d[HS_BIT]          = hs_d;
        word_d[YC_MSB:YC_LSB]   = vc;
        word_d[XC_MSB:XC_LSB]   = hc;
        word_d[RGB_MSB:RGB_LSB] = active_d ? active_rgb : 3'b000;
    end

    // Pulses share the output register stage with the stream word
    always_ff @(posedge px_clk) begin
        if (reset) begin
            stream_q      <= IDLE_WORD;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            stream_q      <= word_d;
            frame_start_q <= (hc == '0) && (vc == '0);
            line_start_q  <= (hc == '0);
        end
    end

    assign RGBStr_o    = stream_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;

endmodule

// File: doc/vga_stream_source.md
VGA_STREAM_SOURCE -- requirements
Module: vga_stream_source

Interface
REQ-001 The block SHALL have the parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have the parameters H_FP=16, H_SYNC=96 and H_BP=48, meaning the horizontal porch and sync widths in pixels; the line total SHALL be 800.
REQ-003 The block SHALL have the parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 The block SHALL have the parameters V_FP=10, V_SYNC=2 and V_BP=33, meaning the vertical porch and sync widths in lines; the frame total SHALL be 525.
REQ-005 The block SHALL have the port px_clk, input, 1 bit, the pixel clock; it is the block's only clock.
REQ-006 The block SHALL have the port reset, input, 1 bit; reset is synchronous and active-high.
REQ-007 The block SHALL have the port bg_color, input, 3 bits, {B,G,R}, giving the active-area colour when the test pattern is absent.
REQ-008 The block SHALL have the port RGBStr_o, output reg, 26 bits, the RGB stream with this layout:
- bit 0: Active
- bit 1: VS
- bit 2: HS
- bits 12:3: YC
- bits 22:13: XC
- bit 23: R
- bit 24: G
- bit 25: B
REQ-009 The block SHALL have the port frame_start, output reg, 1 bit, a one-cycle pulse aligned with the stream word where XC=0 and YC=0.
REQ-010 The block SHALL have the port line_start, output reg, 1 bit, a one-cycle pulse aligned with every stream word where XC=0.

Function
REQ-011 The block SHALL keep a horizontal counter hc that counts 0..799 and wraps to 0.
REQ-012 The block SHALL advance a vertical counter vc (0..524) only on the cycle in which hc wraps; vc SHALL wrap 524->0 on that same cycle.
REQ-013 RGBStr_o SHALL be registered with exactly one px_clk of latency from the counter state: XC=hc and YC=vc, each zero-extended to 10 bits.
REQ-014 Active SHALL be 1 iff hc<H_ACTIVE and vc<V_ACTIVE.
REQ-015 HS SHALL be 0 (negative polarity) iff hc is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751; otherwise HS SHALL be 1.
REQ-016 VS SHALL be 0 iff vc is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491; otherwise VS SHALL be 1, and VS SHALL be independent of hc.
REQ-017 RGB SHALL be 3'b000 whenever Active=0.
REQ-018 RGB with Active=1 SHALL follow REQ-024/REQ-025.
REQ-019 frame_start and line_start SHALL be registered in the same stage as RGBStr_o, so they are never skewed from it.
REQ-020 A bg_color change SHALL affect the stream word produced on the next clock edge; no other input sampling is permitted.

Reset
REQ-021 While reset=1 at a px_clk edge, the block SHALL set:
- hc=0 and vc=0, and the bar counter to 0
- RGBStr_o to 26'b0 except HS=1 and VS=1
- frame_start=0 and line_start=0
REQ-022 On the first edge after reset deasserts, RGBStr_o SHALL carry XC=0, YC=0, Active=1, and frame_start=1 and line_start=1.
REQ-023 A reset asserted mid-line or mid-frame SHALL abandon the current frame with no partial sync pulse extended; HS and VS SHALL read 1 on the next output.

Configuration
REQ-024 With TEST_PATTERN_EN defined, active RGB SHALL be a colour-bar index with {B,G,R}=bar:
- bar is 0..7, each bar 80 pixels wide (H_ACTIVE/8)
- bar is held by a sequential sub-counter that resets to 0 at hc=0; no divider is used
- bg_color SHALL be ignored
REQ-025 With TEST_PATTERN_EN undefined, active RGB SHALL equal bg_color, and the bar logic SHALL be absent.

Structure
REQ-026 The shared package vga_stream_pkg SHALL hold:
- the stream field bit positions (Active, VS, HS, YC, XC, R, G, B, RGB, VGA)
- the default 640x480 timing constants
- the 26-bit stream word typedef
REQ-027 The design SHALL contain exactly one sub-module, mod_counter: a parameterised wrap counter with enable and synchronous reset, instantiated for hc and for vc.

Verification
REQ-028 Scenario reset release: deassert reset -> first word has XC=0, YC=0, Active=1, HS=1, VS=1, and frame_start=1.
REQ-029 Scenario line timing: run one line -> Active high for exactly 640 cycles; HS low for exactly 96 cycles starting at XC=656; line_start period is 800 cycles.
REQ-030 Scenario frame timing: run 2 frames -> VS low during YC 490..491 only (1600 cycles); frame_start period is 420000 cycles; YC wraps 524->0 at XC 799->0.
REQ-031 Scenario blanking colour: bg_color=3'b101 -> RGB=101 for all Active words and 000 for every blank word.
REQ-032 Scenario test pattern (TEST_PATTERN_EN defined): RGB at XC=0, 79, 80, 559, 560 and 639 equals 0, 0, 1, 6, 7 and 7.
REQ-033 Scenario mid-frame reset: pulse reset at XC=700, YC=491 -> next word has HS=VS=1 and Active=0; after release the stream restarts at XC=0, YC=0.
